// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: captures decoded control/operands, inserts bubbles on
// load-use or flush, holds on stall, and counts load-use bubbles with saturation.
module id_ex_pipe #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              bubble_i,
  input  logic              flush_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic [DATA_W-1:0] PC_i,
  input  logic [DATA_W-1:0] RS1data_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [9:0]        Funct_i,
  input  logic [4:0]        RS1_i,
  input  logic [4:0]        RS2_i,
  input  logic [4:0]        RD_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [1:0]        ALUOp_o,
  output logic              ALUSrc_o,
  output logic [DATA_W-1:0] PC_o,
  output logic [DATA_W-1:0] RS1data_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [DATA_W-1:0] Imm_o,
  output logic [9:0]        Funct_o,
  output logic [4:0]        RS1_o,
  output logic [4:0]        RS2_o,
  output logic [4:0]        RD_o,
  output logic              Valid_o,
  output logic [CNT_W-1:0]  BubbleCnt_o
);

  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic clear;
  logic count_en;

  // Bubble and flush both squash the entry; only a bubble is counted.
  always_comb begin
    clear    = 1'b0;
    count_en = 1'b0;
    if (!stall_i) begin
      clear    = flush_i | bubble_i;
      count_en = bubble_i && (BubbleCnt_o != CNT_MAX);
    end else begin
      clear    = 1'b0;
      count_en = 1'b0;
    end
  end

  // Pipeline payload: reset > stall hold > squash > load.
  always_ff @(posedge clk_i) begin
    if (rst_i || (!stall_i && clear)) begin
      RegWrite_o <= 1'b0;
      MemtoReg_o <= 1'b0;
      MemRead_o  <= 1'b0;
      MemWrite_o <= 1'b0;
      ALUOp_o    <= 2'b00;
      ALUSrc_o   <= 1'b0;
      PC_o       <= DATA_ZERO;
      RS1data_o  <= DATA_ZERO;
      RS2data_o  <= DATA_ZERO;
      Imm_o      <= DATA_ZERO;
      Funct_o    <= 10'd0;
      RS1_o      <= 5'd0;
      RS2_o      <= 5'd0;
      RD_o       <= 5'd0;
      Valid_o    <= 1'b0;
    end else if (!stall_i) begin
      RegWrite_o <= RegWrite_i;
      MemtoReg_o <= MemtoReg_i;
      MemRead_o  <= MemRead_i;
      MemWrite_o <= MemWrite_i;
      ALUOp_o    <= ALUOp_i;
      ALUSrc_o   <= ALUSrc_i;
      PC_o       <= PC_i;
      RS1data_o  <= RS1data_i;
      RS2data_o  <= RS2data_i;
      Imm_o      <= Imm_i;
      Funct_o    <= Funct_i;
      RS1_o      <= RS1_i;
      RS2_o      <= RS2_i;
      RD_o       <= RD_i;
      Valid_o    <= 1'b1;
    end else begin
      Valid_o    <= Valid_o;
    end
  end

  // Saturating load-use bubble counter; never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      BubbleCnt_o <= {CNT_W{1'b0}};
    end else if (count_en) begin
      BubbleCnt_o <= BubbleCnt_o + CNT_ONE;
    end else begin
      BubbleCnt_o <= BubbleCnt_o;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe; counter width reduced to 2 bits
// so saturation is reachable quickly.
module tb_id_ex_pipe;
  localparam int DW = 32;
  localparam int CW = 2;

  logic clk_i = 1'b0;
  logic rst_i, stall_i, bubble_i, flush_i;
  logic RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
  logic [1:0] ALUOp_i;
  logic [DW-1:0] PC_i, RS1data_i, RS2data_i, Imm_i;
  logic [9:0] Funct_i;
  logic [4:0] RS1_i, RS2_i, RD_i;
  logic RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Valid_o;
  logic [1:0] ALUOp_o;
  logic [DW-1:0] PC_o, RS1data_o, RS2data_o, Imm_o;
  logic [9:0] Funct_o;
  logic [4:0] RS1_o, RS2_o, RD_o;
  logic [CW-1:0] BubbleCnt_o;

  int errors = 0;
  int checks = 0;

  id_ex_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .bubble_i(bubble_i), .flush_i(flush_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .PC_i(PC_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .Funct_i(Funct_i),
    .RS1_i(RS1_i), .RS2_i(RS2_i), .RD_i(RD_i),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .PC_o(PC_o),
    .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o), .Funct_o(Funct_o),
    .RS1_o(RS1_o), .RS2_o(RS2_o), .RD_o(RD_o), .Valid_o(Valid_o), .BubbleCnt_o(BubbleCnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    rst_i = 1'b0; stall_i = 1'b0; bubble_i = 1'b0; flush_i = 1'b0;
    RegWrite_i = 1'b0; MemtoReg_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    ALUOp_i = 2'b00; ALUSrc_i = 1'b0; PC_i = 32'd0; RS1data_i = 32'd0;
    RS2data_i = 32'd0; Imm_i = 32'd0; Funct_i = 10'd0; RS1_i = 5'd0; RS2_i = 5'd0; RD_i = 5'd0;
  endtask

  task automatic set_busy();
    RegWrite_i = 1'b1; MemtoReg_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b1;
    ALUOp_i = 2'b11; ALUSrc_i = 1'b1; PC_i = 32'hDEAD_BEEF; RS1data_i = 32'h1111_2222;
    RS2data_i = 32'h3333_4444; Imm_i = 32'h5555_6666; Funct_i = 10'h3FF;
    RS1_i = 5'd31; RS2_i = 5'd30; RD_i = 5'd29;
  endtask

  task automatic test_reset();
    set_idle();
    set_busy();
    rst_i = 1'b1;
    tick();
    tick();
    checks++;
    if ({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUOp_o, ALUSrc_o, Valid_o} !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUOp_o, ALUSrc_o, Valid_o});
    end
    checks++;
    if ({PC_o, RS1data_o, RS2data_o, Imm_o} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {PC_o, RS1data_o, RS2data_o, Imm_o});
    end
    checks++;
    if ({Funct_o, RS1_o, RS2_o, RD_o, BubbleCnt_o} !== 27'd0) begin
      errors++;
      $display("FAIL reset_addr_cnt: got %h expected 0", {Funct_o, RS1_o, RS2_o, RD_o, BubbleCnt_o});
    end
  endtask

  task automatic test_normal_load();
    set_idle();
    RegWrite_i = 1'b1; RD_i = 5'd7; RS1data_i = 32'h0000_1234; Imm_i = 32'hFFFF_FFF0;
    Funct_i = 10'h205; RS2_i = 5'd12; PC_i = 32'h0000_0040;
    tick();
    checks++;
    if (RegWrite_o !== 1'b1) begin errors++; $display("FAIL load_regwrite: got %b expected 1", RegWrite_o); end
    checks++;
    if (RD_o !== 5'd7) begin errors++; $display("FAIL load_rd: got %0d expected 7", RD_o); end
    checks++;
    if (RS1data_o !== 32'h0000_1234) begin errors++; $display("FAIL load_rs1data: got %h expected 00001234", RS1data_o); end
    checks++;
    if (Imm_o !== 32'hFFFF_FFF0) begin errors++; $display("FAIL load_imm: got %h expected fffffff0", Imm_o); end
    checks++;
    if ({Funct_o, RS2_o, PC_o} !== {10'h205, 5'd12, 32'h0000_0040}) begin
      errors++; $display("FAIL load_misc: got %h %h %h expected 205 0c 00000040", Funct_o, RS2_o, PC_o);
    end
    checks++;
    if (Valid_o !== 1'b1) begin errors++; $display("FAIL load_valid: got %b expected 1", Valid_o); end
  endtask

  task automatic test_load_use();
    set_idle();
    MemRead_i = 1'b1; RegWrite_i = 1'b1; MemtoReg_i = 1'b1; RD_i = 5'd5; PC_i = 32'h0000_0100;
    tick();
    checks++;
    if ({MemRead_o, RD_o} !== {1'b1, 5'd5}) begin
      errors++; $display("FAIL lu_load: got memread=%b rd=%0d expected 1 5", MemRead_o, RD_o);
    end
    bubble_i = 1'b1; RS1_i = 5'd5; RD_i = 5'd8; PC_i = 32'h0000_0104;
    tick();
    checks++;
    if ({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUOp_o, ALUSrc_o, Valid_o} !== 8'd0) begin
      errors++;
      $display("FAIL lu_bubble_ctrl: got %b expected 0",
               {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUOp_o, ALUSrc_o, Valid_o});
    end
    checks++;
    if ({RD_o, RS1_o, PC_o} !== 42'd0) begin
      errors++; $display("FAIL lu_bubble_regs: got rd=%0d rs1=%0d pc=%h expected 0", RD_o, RS1_o, PC_o);
    end
    checks++;
    if (BubbleCnt_o !== 2'd1) begin errors++; $display("FAIL lu_count: got %0d expected 1", BubbleCnt_o); end
    bubble_i = 1'b0; MemRead_i = 1'b0;
    tick();
    checks++;
    if ({Valid_o, RD_o, RS1_o, PC_o, MemRead_o} !== {1'b1, 5'd8, 5'd5, 32'h0000_0104, 1'b0}) begin
      errors++; $display("FAIL lu_reload: got v=%b rd=%0d rs1=%0d pc=%h mr=%b expected 1 8 5 00000104 0",
                         Valid_o, RD_o, RS1_o, PC_o, MemRead_o);
    end
    checks++;
    if (BubbleCnt_o !== 2'd1) begin errors++; $display("FAIL lu_count_hold: got %0d expected 1", BubbleCnt_o); end
  endtask

  task automatic test_stall();
    set_idle();
    RD_i = 5'd9; PC_i = 32'h0000_0200; ALUOp_i = 2'b10; ALUSrc_i = 1'b1;
    tick();
    stall_i = 1'b1; bubble_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      RD_i = 5'(10 + i); PC_i = 32'h0000_0300 + 32'(i); ALUOp_i = 2'b01; ALUSrc_i = 1'b0;
      tick();
      checks++;
      if ({RD_o, PC_o, ALUOp_o, ALUSrc_o, Valid_o, BubbleCnt_o} !==
          {5'd9, 32'h0000_0200, 2'b10, 1'b1, 1'b1, 2'd1}) begin
        errors++; $display("FAIL stall_hold[%0d]: got rd=%0d pc=%h op=%b src=%b v=%b cnt=%0d expected 9 00000200 10 1 1 1",
                           i, RD_o, PC_o, ALUOp_o, ALUSrc_o, Valid_o, BubbleCnt_o);
      end
    end
    stall_i = 1'b0; bubble_i = 1'b0;
    tick();
    checks++;
    if ({RD_o, PC_o, ALUOp_o, ALUSrc_o, Valid_o} !== {5'd12, 32'h0000_0302, 2'b01, 1'b0, 1'b1}) begin
      errors++; $display("FAIL stall_release: got rd=%0d pc=%h op=%b src=%b v=%b expected 12 00000302 01 0 1",
                         RD_o, PC_o, ALUOp_o, ALUSrc_o, Valid_o);
    end
  endtask

  task automatic test_flush();
    set_idle();
    flush_i = 1'b1; MemWrite_i = 1'b1; RD_i = 5'd3; Imm_i = 32'h0000_0ABC;
    tick();
    checks++;
    if ({MemWrite_o, RD_o, Valid_o, Imm_o} !== 39'd0) begin
      errors++; $display("FAIL flush_clear: got mw=%b rd=%0d v=%b imm=%h expected 0", MemWrite_o, RD_o, Valid_o, Imm_o);
    end
    checks++;
    if (BubbleCnt_o !== 2'd1) begin errors++; $display("FAIL flush_nocount: got %0d expected 1", BubbleCnt_o); end
    bubble_i = 1'b1;
    tick();
    checks++;
    if (BubbleCnt_o !== 2'd2) begin errors++; $display("FAIL flush_bubble_count: got %0d expected 2", BubbleCnt_o); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    set_idle();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bubble_i = 1'b1;
      tick();
      bubble_i = 1'b0;
      tick();
      checks++;
      if (BubbleCnt_o !== exp_seq[i]) begin
        errors++; $display("FAIL sat_pulse[%0d]: got %0d expected %0d", i, BubbleCnt_o, exp_seq[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_idle();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; bubble_i = 1'b1;
    tick();
    tick();
    bubble_i = 1'b0; RD_i = 5'd4; RegWrite_i = 1'b1; PC_i = 32'h0000_0500;
    tick();
    checks++;
    if ({BubbleCnt_o, RD_o, Valid_o} !== {2'd2, 5'd4, 1'b1}) begin
      errors++; $display("FAIL mid_setup: got cnt=%0d rd=%0d v=%b expected 2 4 1", BubbleCnt_o, RD_o, Valid_o);
    end
    stall_i = 1'b1; rst_i = 1'b1;
    tick();
    checks++;
    if ({BubbleCnt_o, RD_o, Valid_o, RegWrite_o, PC_o} !== 41'd0) begin
      errors++; $display("FAIL mid_reset: got cnt=%0d rd=%0d v=%b rw=%b pc=%h expected 0",
                         BubbleCnt_o, RD_o, Valid_o, RegWrite_o, PC_o);
    end
    set_idle();
    RD_i = 5'd6;
    tick();
    checks++;
    if ({RD_o, Valid_o} !== {5'd6, 1'b1}) begin
      errors++; $display("FAIL mid_resume: got rd=%0d v=%b expected 6 1", RD_o, Valid_o);
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_normal_load();
    test_load_use();
    test_stall();
    test_flush();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register of the 5-stage core; sits between decode and execute, directly downstream of the load-use hazard detector.
- Captures decoded control, operand data, immediate and register addresses on every enabled clock edge.
- Inserts a bubble when the hazard detector requests one, and holds its contents on a global stall.
- Its MemRead_o and RD_o outputs feed back into the hazard detector as the ID/EX MemRead and ID/EX RD inputs; it also keeps a saturating count of load-use bubbles inserted.

Parameters:
- DATA_W, 32, width of operand, immediate and PC fields.
- CNT_W, 16, width of the bubble performance counter.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- stall_i  in  1  global pipeline stall (memory wait); hold all state.
- bubble_i  in  1  bubble request from hazard detection (load-use).
- flush_i  in  1  control-flow flush of the instruction in ID.
- RegWrite_i / RegWrite_o  in/out  1  register write enable.
- MemtoReg_i / MemtoReg_o  in/out  1  write-back source select.
- MemRead_i / MemRead_o  in/out  1  load; MemRead_o is the ID/EX MemRead input of hazard detection.
- MemWrite_i / MemWrite_o  in/out  1  store.
- ALUOp_i / ALUOp_o  in/out  2  ALU control class.
- ALUSrc_i / ALUSrc_o  in/out  1  ALU operand B select (immediate).
- PC_i / PC_o  in/out  DATA_W  instruction address.
- RS1data_i / RS1data_o  in/out  DATA_W  register file read port 1.
- RS2data_i / RS2data_o  in/out  DATA_W  register file read port 2.
- Imm_i / Imm_o  in/out  DATA_W  sign-extended immediate.
- Funct_i / Funct_o  in/out  10  {funct7, funct3}.
- RS1_i / RS1_o  in/out  5  source register 1 address (forwarding).
- RS2_i / RS2_o  in/out  5  source register 2 address (forwarding).
- RD_i / RD_o  in/out  5  destination address; RD_o feeds the ID/EX RD input of hazard detection.
- Valid_o  out  1  EX holds a real instruction (1) or a bubble (0).
- BubbleCnt_o  out  CNT_W  count of load-use bubbles inserted.

Behaviour:
- All outputs are registered; there is no combinational path from input to output. Latency is 1 cycle.
- Reset: when rst_i=1 at a clock edge, all outputs go to 0, including Valid_o and BubbleCnt_o. Reset overrides every other input, including mid-stall.
- Update priority per edge is rst_i > stall_i > (flush_i | bubble_i) > normal load.
- Stall (stall_i=1): every register holds its value. A bubble_i or flush_i asserted in the same cycle is ignored and not counted; the upstream hazard logic re-asserts it after the stall.
- Bubble or flush (not stalled, flush_i=1 or bubble_i=1):
  - RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUOp_o, ALUSrc_o, Valid_o go to 0.
  - RD_o, RS1_o, RS2_o go to 0, so forwarding and hazard compares cannot match x0-free logic.
  - PC_o, RS1data_o, RS2data_o, Imm_o, Funct_o go to 0.
- Clearing MemRead_o on a bubble guarantees the hazard detector deasserts next cycle. A single load-use hazard yields exactly one bubble.
- Normal load: all *_o take the corresponding *_i, and Valid_o=1.
- Counter: BubbleCnt_o increments by 1 on an edge where bubble_i=1, stall_i=0 and rst_i=0.
  - Flush-only cycles do not increment it.
  - bubble_i=1 and flush_i=1 together count once.
  - The counter saturates at 2^CNT_W-1 and never wraps.
- No X propagation: every register has a defined value after the first reset edge.

Test Plan:
- Reset and normal load: assert rst_i 2 cycles with inputs nonzero → all outputs 0. Release, drive RegWrite_i=1, RD_i=7, RS1data_i=0x1234, Imm_i=0xFFFFFFF0 → next edge RegWrite_o=1, RD_o=7, RS1data_o=0x1234, Imm_o=0xFFFFFFF0, Valid_o=1.
- Load-use bubble: load with MemRead_i=1, RD_i=5, then next cycle bubble_i=1 with RS1_i=5.
  - Expected: MemRead_o=1, RD_o=5 after the first edge; all control bits, RD_o and Valid_o=0 after the second edge.
  - Expected: BubbleCnt_o=1; the following cycle reloads normally.
- Stall hold: set outputs with RD_o=9, then stall_i=1 for 3 cycles with changing inputs and bubble_i=1 → outputs unchanged, BubbleCnt_o unchanged. stall_i=0 → next edge loads current inputs.
- Flush: flush_i=1 with MemWrite_i=1, RD_i=3 → MemWrite_o=0, RD_o=0, Valid_o=0, BubbleCnt_o unchanged. flush_i=1 plus bubble_i=1 → counter increments by exactly 1.
- Counter saturation (CNT_W=2): 5 unstalled bubble_i pulses → BubbleCnt_o sequence 1,2,3,3,3.
- Reset mid-operation: BubbleCnt_o=2, stall_i=1, rst_i=1 for one edge → all outputs 0 and BubbleCnt_o=0 despite the stall.
